step_controller: RTL and testbench
==================================

Name: step_controller

Overview:
- Upstream of the single-cycle RISC-V core: generates `cpu_tick`, the one-cycle strobe on which the PC, register file and data memory update.
- Takes a raw step push-button and a run switch; produces either single-step ticks or free-running ticks at a divided rate.
- Optionally halts on a PC breakpoint.
- Exposes a retired-cycle counter and status for the VGA debug overlay.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronized input must hold a level before the debounced level changes (10 ms at 50 MHz).
- RUN_DIV, 5000000, clk cycles between ticks in RUN (10 Hz at 50 MHz); legal range >= 2.
- CNT_W, 32, width of `cycle_count`.

Ports:
- clk  in  1  system clock (50 MHz board clock).
- rst_n  in  1  asynchronous active-low reset.
- btn_step  in  1  raw step push-button, active-high, asynchronous to clk.
- sw_run  in  1  raw run switch, 1 = free-run, asynchronous to clk.
- pc  in  32  current core PC.
- bp_addr  in  32  breakpoint address.
- bp_valid  in  1  breakpoint armed.
- cpu_tick  out  1  one-clk-wide core update strobe.
- running  out  1  state == RUN.
- halted  out  1  state == BREAK.
- cycle_count  out  CNT_W  number of ticks issued since reset.

Behaviour:
- **Clock and reset:** one clock, `clk`. Reset is asynchronous, active-low, on `rst_n`. Every flop clears on `rst_n` low, including mid-debounce and mid-prescale.
  - Reset values: state = IDLE, `cpu_tick` = 0, `running` = 0, `halted` = 0, `cycle_count` = 0, prescaler = 0, debounced levels = 0.
- **Input conditioning:** `btn_step` and `sw_run` each pass a 2-flop synchronizer, then a debouncer.
  - Debounced level changes only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce back restarts the count.
  - `step_req` = single-cycle pulse on a debounced `btn_step` 0->1 edge.
  - `run_lvl` = debounced `sw_run`.
- **FSM states:** IDLE, STEP, RUN, BREAK.
  - IDLE:
    - `run_lvl` = 1 -> RUN, prescaler cleared. This takes priority over a same-cycle `step_req`, which is discarded.
    - Otherwise `step_req` -> STEP.
  - STEP: `cpu_tick` = 1 for this one cycle; next state IDLE.
  - RUN:
    - Prescaler counts 0..RUN_DIV-1 and wraps to 0.
    - At count RUN_DIV-1: if breakpoint hit (see Optional Feature), go to BREAK with no tick; else `cpu_tick` = 1.
    - `run_lvl` = 0 -> IDLE with prescaler cleared. This takes priority over a same-cycle terminal count, so no tick is issued.
    - `step_req` in RUN is ignored.
  - BREAK:
    - `step_req` -> STEP, which issues one tick to step past the breakpoint and then goes to IDLE. From IDLE, if `run_lvl` is still 1, RUN resumes; `pc` has moved, so there is no immediate re-break.
    - `run_lvl` = 0 -> IDLE.
    - If both happen in the same cycle, `step_req` wins.
- **Timing:**
  - `cpu_tick` is registered: asserted the cycle after the decision, never more than 1 cycle wide, never on consecutive cycles.
  - Step latency: `cpu_tick` asserts 2 cycles after the `step_req` pulse.
- **`cycle_count`:** +1 on every `cpu_tick`; saturates at all-ones, no wrap.
- **Status outputs:** `running` and `halted` are registered decodes of the state.

Optional Feature:
- Macro: STEP_CTRL_BREAKPOINT_EN.
- Defined: breakpoint hit = `bp_valid` && (`pc` == `bp_addr`), evaluated at the RUN terminal count. BREAK state is reachable.
- Undefined:
  - `bp_addr` and `bp_valid` are unused and must not generate logic.
  - BREAK is unreachable and `halted` is tied to 0.
  - RUN always ticks at the terminal count.

Decomposition:
- Package `step_ctrl_pkg`: state enum (IDLE=2'd0, STEP=2'd1, RUN=2'd2, BREAK=2'd3), default DEBOUNCE_CYCLES and RUN_DIV constants, and a `clog2` helper for counter widths.
- Sub-module `debouncer`: synchronizer plus debounce counter. Parameter DEBOUNCE_CYCLES; ports `clk`, `rst_n`, `din`, `dout`, `rise`. Instantiated twice.

Test Plan (bench uses DEBOUNCE_CYCLES=4, RUN_DIV=8):
- **Bounce rejection:** `btn_step` toggles 1,0,1,0 at 2-cycle intervals, then held 1 for 10 cycles -> exactly one `cpu_tick`; `cycle_count` = 1.
- **RUN rate:** `sw_run` = 1 held -> first tick 8 cycles after entering RUN, then every 8 cycles. After 5 ticks `cycle_count` = 5. `btn_step` presses in RUN produce no extra ticks.
- **Breakpoint (EN defined):** `bp_valid` = 1, `bp_addr` = 0x0000000C; bench advances `pc` by 4 per tick from 0 -> 3 ticks, then `halted` = 1 with `pc` = 0x0C and no further ticks. One step press -> exactly one tick, `pc` = 0x10, RUN resumes and `halted` = 0.
- **Breakpoint (EN undefined):** same stimulus -> `halted` stays 0 and ticks continue past 0x0C.
- **Run stop at terminal count:** `sw_run` debounced falling edge lands on prescaler = 7 -> no tick; state IDLE; `running` = 0.
- **Reset mid-operation:** `rst_n` low for 1 cycle at prescaler = 5 in RUN with `cycle_count` = 3 -> immediately `cycle_count` = 0, `running` = 0, `cpu_tick` = 0. After release with `sw_run` still 1 -> RUN re-entered after DEBOUNCE_CYCLES+2 cycles, first tick 8 cycles later.
- **Saturation:** force `cycle_count` to all-ones and issue a step -> value remains all-ones.

Source files
------------

// File: rtl/step_ctrl_pkg.sv
// Shared types and defaults for the single-cycle core step controller.
package step_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STEP  = 2'd1,
        RUN   = 2'd2,
        BREAK = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 500000;
    localparam int DEF_RUN_DIV         = 5000000;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/debouncer.sv
// Two-flop synchronizer followed by a hold-time debouncer; rise pulses for
// one cycle alongside the debounced 0->1 transition.
module debouncer
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise
);

    localparam int CW = clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dout  <= 1'b0;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            rise  <= 1'b0;
            // Any sample agreeing with the current level restarts the hold count.
            if (sync2 != dout) begin
                if (cnt == CNT_LAST) begin
                    dout <= sync2;
                    rise <= sync2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/step_controller.sv
// Generates cpu_tick for the single-cycle core from a step button and run switch.
// Breakpoint halting is built only when STEP_CTRL_BREAKPOINT_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for a step press or the run switch
//   STEP  | issue exactly one tick, then back to IDLE
//   RUN   | free-run, one tick every RUN_DIV cycles
//   BREAK | halted at the breakpoint PC until step or run off
module step_controller
    import step_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RUN_DIV         = DEF_RUN_DIV,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_step,
    input  logic             sw_run,
    input  logic [31:0]      pc,
    input  logic [31:0]      bp_addr,
    input  logic             bp_valid,
    output logic             cpu_tick,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int PW = clog2(RUN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(RUN_DIV - 1);

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic [PW-1:0] presc_next;
    logic          step_req;
    logic          run_lvl;
    logic          bp_hit;
    logic          terminal;
    logic          tick_next;
    logic          running_next;
    logic          unused_step_lvl;
    logic          unused_run_rise;

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (btn_step),
        .dout  (unused_step_lvl),
        .rise  (step_req)
    );

    debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sw_run),
        .dout  (run_lvl),
        .rise  (unused_run_rise)
    );

`ifdef STEP_CTRL_BREAKPOINT_EN
    assign bp_hit = bp_valid && (pc == bp_addr);
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr, bp_valid};
    assign bp_hit    = 1'b0;
`endif

    assign terminal = (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            presc <= '0;
        end else begin
            state <= state_next;
            presc <= presc_next;
        end
    end

    // Prescaler only advances while staying in RUN; every other path clears it.
    always_comb begin
        state_next = state;
        presc_next = '0;
        case (state)
            IDLE: begin
                if (run_lvl) begin
                    state_next = RUN;
                end else if (step_req) begin
                    state_next = STEP;
                end
            end
            STEP: state_next = IDLE;
            RUN: begin
                if (!run_lvl) begin
                    state_next = IDLE;
                end else if (terminal) begin
                    if (bp_hit) begin
                        state_next = BREAK;
                    end
                end else begin
                    presc_next = presc + PW'(1);
                end
            end
            BREAK: begin
                if (step_req) begin
                    state_next = STEP;
                end else if (!run_lvl) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tick_next    = (state == STEP) ||
                       ((state == RUN) && run_lvl && terminal && !bp_hit);
        running_next = (state_next == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_tick    <= 1'b0;
            running     <= 1'b0;
            cycle_count <= '0;
        end else begin
            cpu_tick <= tick_next;
            running  <= running_next;
            if (tick_next && (cycle_count != {CNT_W{1'b1}})) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

`ifdef STEP_CTRL_BREAKPOINT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted <= 1'b0;
        end else begin
            halted <= (state_next == BREAK);
        end
    end
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_step_controller.sv
// Directed bench for step_controller with DEBOUNCE_CYCLES=4, RUN_DIV=8; a second
// instance with a 2-bit cycle_count exercises saturation.
module tb_step_controller;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        btn_step = 1'b0;
    logic        sw_run   = 1'b0;
    logic [31:0] pc       = 32'd0;
    logic [31:0] bp_addr  = 32'd0;
    logic        bp_valid = 1'b0;

    logic        cpu_tick;
    logic        running;
    logic        halted;
    logic [31:0] cycle_count;
    logic        sat_tick;
    logic        sat_running;
    logic        sat_halted;
    logic [1:0]  sat_count;

    int   vectors      = 0;
    int   errors       = 0;
    int   cyc          = 0;
    int   double_ticks = 0;
    logic prev_tick    = 1'b0;
    logic pc_model_en  = 1'b0;

    step_controller #(.DEBOUNCE_CYCLES(4), .RUN_DIV(8), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_step    (btn_step),
        .sw_run      (sw_run),
        .pc          (pc),
        .bp_addr     (bp_addr),
        .bp_valid    (bp_valid),
        .cpu_tick    (cpu_tick),
        .running     (running),
        .halted      (halted),
        .cycle_count (cycle_count)
    );

    step_controller #(.DEBOUNCE_CYCLES(4), .RUN_DIV(8), .CNT_W(2)) dut_sat (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_step    (btn_step),
        .sw_run      (sw_run),
        .pc          (pc),
        .bp_addr     (bp_addr),
        .bp_valid    (bp_valid),
        .cpu_tick    (sat_tick),
        .running     (sat_running),
        .halted      (sat_halted),
        .cycle_count (sat_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Core PC model: advances by 4 on every tick, held at 0 when disabled.
    always @(negedge clk) begin
        if (cpu_tick === 1'b1 && prev_tick === 1'b1) double_ticks++;
        prev_tick = cpu_tick;
        if (!pc_model_en) pc = 32'd0;
        else if (cpu_tick === 1'b1) pc = pc + 32'd4;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply_reset();
        btn_step = 1'b0;
        sw_run   = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Returns the cycle number of the next tick, or -1 if none within max_cycles.
    task automatic wait_tick(input int max_cycles, output int at);
        at = -1;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (cpu_tick === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (cpu_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", cpu_tick); end
        vectors++;
        if (running !== 1'b0) begin errors++; $display("FAIL reset_running: got %b want 0", running); end
        vectors++;
        if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", halted); end
        vectors++;
        if (cycle_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", cycle_count); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bounce();
        int c0, t;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            btn_step = (k % 2 == 0);
            repeat (2) @(negedge clk);
        end
        btn_step = 1'b1;
        c0 = cyc;
        wait_tick(10, t);
        vectors++;
        if (t !== c0 + 8) begin errors++; $display("FAIL bounce_latency: tick at %0d want %0d", t, c0 + 8); end
        repeat (2) @(negedge clk);
        btn_step = 1'b0;
        wait_tick(12, t);
        vectors++;
        if (t !== -1) begin errors++; $display("FAIL bounce_extra_tick: tick at %0d want none", t); end
        vectors++;
        if (cycle_count !== 32'd1) begin errors++; $display("FAIL bounce_count: got %0d want 1", cycle_count); end
    endtask

    task automatic test_run_rate();
        int c0, t, prev;
        apply_reset();
        sw_run = 1'b1;
        c0 = cyc;
        wait_tick(20, t);
        vectors++;
        if (t !== c0 + 15) begin errors++; $display("FAIL run_first_tick: at %0d want %0d", t, c0 + 15); end
        prev = c0 + 15;
        btn_step = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            wait_tick(12, t);
            vectors++;
            if (t !== prev + 8) begin errors++; $display("FAIL run_tick_%0d: at %0d want %0d", k, t, prev + 8); end
            prev = prev + 8;
            if (k == 3) btn_step = 1'b0;
            if (k == 4) btn_step = 1'b1;
        end
        btn_step = 1'b0;
        vectors++;
        if (cycle_count !== 32'd5) begin errors++; $display("FAIL run_count: got %0d want 5", cycle_count); end
        vectors++;
        if (running !== 1'b1) begin errors++; $display("FAIL run_running: got %b want 1", running); end
    endtask

    task automatic test_breakpoint();
        int c0, c1, t;
        apply_reset();
        bp_addr     = 32'h0000000C;
        bp_valid    = 1'b1;
        pc_model_en = 1'b1;
        sw_run      = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_tick(20, t);
            vectors++;
            if (t !== c0 + 15 + 8 * k) begin errors++; $display("FAIL bp_tick_%0d: at %0d want %0d", k, t, c0 + 15 + 8 * k); end
        end
`ifdef STEP_CTRL_BREAKPOINT_EN
        wait_tick(16, t);
        vectors++;
        if (t !== -1) begin errors++; $display("FAIL bp_no_tick: tick at %0d want none", t); end
        vectors++;
        if (halted !== 1'b1) begin errors++; $display("FAIL bp_halted: got %b want 1", halted); end
        vectors++;
        if (running !== 1'b0) begin errors++; $display("FAIL bp_running: got %b want 0", running); end
        vectors++;
        if (pc !== 32'h0000000C) begin errors++; $display("FAIL bp_pc: got %0h want c", pc); end
        btn_step = 1'b1;
        c1 = cyc;
        wait_tick(12, t);
        vectors++;
        if (t !== c1 + 8) begin errors++; $display("FAIL bp_step_tick: at %0d want %0d", t, c1 + 8); end
        @(negedge clk);
        vectors++;
        if (pc !== 32'h00000010) begin errors++; $display("FAIL bp_step_pc: got %0h want 10", pc); end
        repeat (4) @(negedge clk);
        btn_step = 1'b0;
        vectors++;
        if (halted !== 1'b0) begin errors++; $display("FAIL bp_resume_halted: got %b want 0", halted); end
        vectors++;
        if (running !== 1'b1) begin errors++; $display("FAIL bp_resume_running: got %b want 1", running); end
        wait_tick(16, t);
        vectors++;
        if (t !== c1 + 17) begin errors++; $display("FAIL bp_resume_tick: at %0d want %0d", t, c1 + 17); end
`else
        wait_tick(16, t);
        vectors++;
        if (t !== c0 + 39) begin errors++; $display("FAIL nobp_tick: at %0d want %0d", t, c0 + 39); end
        @(negedge clk);
        vectors++;
        if (pc !== 32'h00000010) begin errors++; $display("FAIL nobp_pc: got %0h want 10", pc); end
        vectors++;
        if (halted !== 1'b0) begin errors++; $display("FAIL nobp_halted: got %b want 0", halted); end
        vectors++;
        if (running !== 1'b1) begin errors++; $display("FAIL nobp_running: got %b want 1", running); end
        wait_tick(16, t);
        vectors++;
        if (t !== c0 + 47) begin errors++; $display("FAIL nobp_next_tick: at %0d want %0d", t, c0 + 47); end
`endif
        vectors++;
        if (cycle_count !== 32'd5) begin errors++; $display("FAIL bp_count: got %0d want 5", cycle_count); end
        pc_model_en = 1'b0;
        bp_valid    = 1'b0;
        sw_run      = 1'b0;
    endtask

    task automatic test_run_stop();
        int c0, c1, t;
        apply_reset();
        sw_run = 1'b1;
        c0 = cyc;
        wait_tick(20, t);
        vectors++;
        if (t !== c0 + 15) begin errors++; $display("FAIL stop_first_tick: at %0d want %0d", t, c0 + 15); end
        @(negedge clk);
        sw_run = 1'b0;
        wait_tick(16, t);
        vectors++;
        if (t !== -1) begin errors++; $display("FAIL stop_no_tick: tick at %0d want none", t); end
        vectors++;
        if (running !== 1'b0) begin errors++; $display("FAIL stop_running: got %b want 0", running); end
        vectors++;
        if (cycle_count !== 32'd1) begin errors++; $display("FAIL stop_count: got %0d want 1", cycle_count); end
        btn_step = 1'b1;
        c1 = cyc;
        wait_tick(12, t);
        vectors++;
        if (t !== c1 + 8) begin errors++; $display("FAIL stop_idle_step: at %0d want %0d", t, c1 + 8); end
        btn_step = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int c0, r, t;
        apply_reset();
        sw_run = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 3; k++) wait_tick(20, t);
        vectors++;
        if (t !== c0 + 31) begin errors++; $display("FAIL mid_third_tick: at %0d want %0d", t, c0 + 31); end
        repeat (5) @(negedge clk);
        vectors++;
        if (cycle_count !== 32'd3) begin errors++; $display("FAIL mid_pre_count: got %0d want 3", cycle_count); end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (cycle_count !== 32'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", cycle_count); end
        vectors++;
        if (running !== 1'b0) begin errors++; $display("FAIL mid_running: got %b want 0", running); end
        vectors++;
        if (cpu_tick !== 1'b0) begin errors++; $display("FAIL mid_tick: got %b want 0", cpu_tick); end
        @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        repeat (8) @(negedge clk);
        vectors++;
        if (running !== 1'b1) begin errors++; $display("FAIL mid_rerun: got %b want 1", running); end
        wait_tick(10, t);
        vectors++;
        if (t !== r + 15) begin errors++; $display("FAIL mid_first_tick: at %0d want %0d", t, r + 15); end
        sw_run = 1'b0;
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            btn_step = 1'b1;
            repeat (10) @(negedge clk);
            btn_step = 1'b0;
            repeat (10) @(negedge clk);
            if (i == 3) begin
                vectors++;
                if (sat_count !== 2'b11) begin errors++; $display("FAIL sat_reach: got %0d want 3", sat_count); end
            end
        end
        vectors++;
        if (sat_count !== 2'b11) begin errors++; $display("FAIL sat_hold: got %0d want 3", sat_count); end
        vectors++;
        if (cycle_count !== 32'd4) begin errors++; $display("FAIL sat_main_count: got %0d want 4", cycle_count); end
    endtask

    task automatic test_tick_width();
        vectors++;
        if (double_ticks !== 0) begin errors++; $display("FAIL tick_width: got %0d back-to-back ticks want 0", double_ticks); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_run_rate();
        test_breakpoint();
        test_run_stop();
        test_reset_mid();
        test_saturation();
        test_tick_width();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
